alu_muldiv_seq: RTL

Parametrised, handshaked successor to the single-cycle combinational ALU. It executes all RV32I ALU operations with a registered one-cycle result, and adds the RV M-extension (MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU) through an iterative datapath that takes WIDTH cycles. It sits in the EX stage behind a valid/ready handshake, so the pipeline stalls on o_ready/o_valid rather than on fixed timing.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/iter_muldiv.sv | 104 ++++++++++
 rtl/alu_muldiv_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcode encoding, FSM states and opcode-class helpers for the
//            sequential ALU / mul-div unit.
// Revision : 1.0
// ============================================================================
package alu_pkg;

  localparam logic [4:0] C_OP_ADD    = 5'b0_0001;
  localparam logic [4:0] C_OP_SUB    = 5'b0_0010;
  localparam logic [4:0] C_OP_SLL    = 5'b0_0011;
  localparam logic [4:0] C_OP_SLT    = 5'b0_0100;
  localparam logic [4:0] C_OP_SLTU   = 5'b0_0101;
  localparam logic [4:0] C_OP_XOR    = 5'b0_0110;
  localparam logic [4:0] C_OP_SRL    = 5'b0_0111;
  localparam logic [4:0] C_OP_SRA    = 5'b0_1000;
  localparam logic [4:0] C_OP_OR     = 5'b0_1001;
  localparam logic [4:0] C_OP_AND    = 5'b0_1010;
  localparam logic [4:0] C_OP_MUL    = 5'b1_0000;
  localparam logic [4:0] C_OP_MULH   = 5'b1_0001;
  localparam logic [4:0] C_OP_MULHSU = 5'b1_0010;
  localparam logic [4:0] C_OP_MULHU  = 5'b1_0011;
  localparam logic [4:0] C_OP_DIV    = 5'b1_0100;
  localparam logic [4:0] C_OP_DIVU   = 5'b1_0101;
  localparam logic [4:0] C_OP_REM    = 5'b1_0110;
  localparam logic [4:0] C_OP_REMU   = 5'b1_0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // M-extension codes occupy 1_0xxx; divide/remainder are the upper half
  function automatic logic is_muldiv(input logic [4:0] op);
    return (op[4:3] == 2'b10);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op[4:2] == 3'b101);
  endfunction

endpackage
`default_nettype wire

// File: rtl/iter_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : iter_muldiv
// Brief    : Iterative unsigned shift-add multiplier / restoring divider over
//            operand magnitudes, with result signs applied on the final step.
// Revision : 1.0
// ============================================================================
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 div_mode,
  input  logic                 neg_hi,
  input  logic                 neg_rem,
  input  logic [WIDTH-1:0]     mag_a,
  input  logic [WIDTH-1:0]     mag_b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder
);

  localparam int                C_CNT_W = $clog2(WIDTH);
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(WIDTH - 1);

  logic               r_busy;
  logic [C_CNT_W-1:0] r_count;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_b;
  logic               r_div;
  logic               r_neg_hi;
  logic               r_neg_rem;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;
  logic [2*WIDTH-1:0] w_raw_prod;

  // Multiply: r_hi accumulates, r_lo shifts the multiplier out / product in.
  // Divide:   r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
  always_comb begin
    w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    w_shift  = {r_hi, r_lo[WIDTH-1]};
    w_diff   = w_shift - {1'b0, r_b};
    w_hi_nxt = w_sum[WIDTH:1];
    w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    if (r_div) begin
      if (!w_diff[WIDTH]) begin
        w_hi_nxt = w_diff[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_shift[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_count   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_b       <= '0;
      r_div     <= 1'b0;
      r_neg_hi  <= 1'b0;
      r_neg_rem <= 1'b0;
    end else if (start) begin
      r_busy    <= 1'b1;
      r_count   <= '0;
      r_hi      <= '0;
      r_lo      <= mag_a;
      r_b       <= mag_b;
      r_div     <= div_mode;
      r_neg_hi  <= neg_hi;
      r_neg_rem <= neg_rem;
    end else if (r_busy) begin
      r_hi <= w_hi_nxt;
      r_lo <= w_lo_nxt;
      if (r_count == C_LAST) begin
        r_busy <= 1'b0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Results are taken from the step values so the last iteration and the
  // sign fix-up land in the same cycle as done.
  assign done       = r_busy && (r_count == C_LAST);
  assign w_raw_prod = {w_hi_nxt, w_lo_nxt};
  assign product    = r_neg_hi  ? (~w_raw_prod + 1'b1) : w_raw_prod;
  assign quotient   = r_neg_hi  ? (~w_lo_nxt + 1'b1)   : w_lo_nxt;
  assign remainder  = r_neg_rem ? (~w_hi_nxt + 1'b1)   : w_hi_nxt;

endmodule
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_seq
// Brief    : Handshaked RV32I ALU with registered result plus iterative
//            RV M-extension multiply/divide.
// Revision : 1.0
// ============================================================================
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data1,
  input  logic [WIDTH-1:0] i_data2,
  input  logic [4:0]       alu_control,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             zero_flag
);

  localparam logic [WIDTH-1:0] C_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             r_state;
  state_t             w_state_nxt;
  logic [4:0]         r_op;
  logic [WIDTH-1:0]   r_data;
  logic               r_zero;

  logic               w_accept;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_simple;
  logic               w_div_zero;
  logic               w_overflow;
  logic               w_special;
  logic [WIDTH-1:0]   w_special_res;
  logic [WIDTH-1:0]   w_imm;
  logic               w_a_signed;
  logic               w_b_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_start;
  logic               w_iter_done;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH-1:0]   w_quotient;
  logic [WIDTH-1:0]   w_remainder;
  logic [WIDTH-1:0]   w_iter_res;

  assign o_ready   = (r_state == ST_IDLE) && !rst;
  assign o_valid   = (r_state == ST_DONE);
  assign o_data    = r_data;
  assign zero_flag = r_zero;
  assign w_accept  = i_valid && o_ready;
  assign w_shamt   = i_data2[SHAMT_W-1:0];

  always_comb begin
    w_simple = '0;
    case (alu_control)
      C_OP_ADD:  w_simple = i_data1 + i_data2;
      C_OP_SUB:  w_simple = i_data1 - i_data2;
      C_OP_SLL:  w_simple = i_data1 << w_shamt;
      C_OP_SLT:  w_simple = {{(WIDTH-1){1'b0}}, ($signed(i_data1) < $signed(i_data2))};
      C_OP_SLTU: w_simple = {{(WIDTH-1){1'b0}}, (i_data1 < i_data2)};
      C_OP_XOR:  w_simple = i_data1 ^ i_data2;
      C_OP_SRL:  w_simple = i_data1 >> w_shamt;
      C_OP_SRA:  w_simple = WIDTH'($signed(i_data1) >>> w_shamt);
      C_OP_OR:   w_simple = i_data1 | i_data2;
      C_OP_AND:  w_simple = i_data1 & i_data2;
      default:   w_simple = '0;
    endcase
  end

  // Divide-by-zero and signed overflow bypass the iterative datapath
  assign w_div_zero = (i_data2 == '0);
  assign w_overflow = (i_data1 == C_MOST_NEG) && (i_data2 == '1) &&
                      ((alu_control == C_OP_DIV) || (alu_control == C_OP_REM));
  assign w_special  = is_div(alu_control) && (w_div_zero || w_overflow);

  always_comb begin
    w_special_res = '0;
    case (alu_control)
      C_OP_DIV, C_OP_DIVU: w_special_res = w_div_zero ? '1 : i_data1;
      C_OP_REM, C_OP_REMU: w_special_res = w_div_zero ? i_data1 : '0;
      default:             w_special_res = '0;
    endcase
  end

  assign w_imm = w_special ? w_special_res : w_simple;

  assign w_a_signed = (alu_control == C_OP_MULH) || (alu_control == C_OP_MULHSU) ||
                      (alu_control == C_OP_DIV)  || (alu_control == C_OP_REM);
  assign w_b_signed = (alu_control == C_OP_MULH) || (alu_control == C_OP_DIV) ||
                      (alu_control == C_OP_REM);
  assign w_a_neg    = w_a_signed && i_data1[WIDTH-1];
  assign w_b_neg    = w_b_signed && i_data2[WIDTH-1];
  assign w_mag_a    = w_a_neg ? (~i_data1 + 1'b1) : i_data1;
  assign w_mag_b    = w_b_neg ? (~i_data2 + 1'b1) : i_data2;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!is_muldiv(alu_control) || w_special) begin
            w_state_nxt = ST_DONE;
          end else if (is_div(alu_control)) begin
            w_state_nxt = ST_DIV;
          end else begin
            w_state_nxt = ST_MUL;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (w_iter_done) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_start = w_accept && ((w_state_nxt == ST_MUL) || (w_state_nxt == ST_DIV));

  iter_muldiv #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (w_start),
    .div_mode  (is_div(alu_control)),
    .neg_hi    (w_a_neg ^ w_b_neg),
    .neg_rem   (w_a_neg),
    .mag_a     (w_mag_a),
    .mag_b     (w_mag_b),
    .done      (w_iter_done),
    .product   (w_product),
    .quotient  (w_quotient),
    .remainder (w_remainder)
  );

  always_comb begin
    w_iter_res = '0;
    case (r_op)
      C_OP_MUL:                              w_iter_res = w_product[WIDTH-1:0];
      C_OP_MULH, C_OP_MULHSU, C_OP_MULHU:    w_iter_res = w_product[2*WIDTH-1:WIDTH];
      C_OP_DIV, C_OP_DIVU:                   w_iter_res = w_quotient;
      C_OP_REM, C_OP_REMU:                   w_iter_res = w_remainder;
      default:                               w_iter_res = '0;
    endcase
  end

  // Result register only changes when entering DONE, so it holds under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= '0;
      r_data <= '0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_op <= alu_control;
      if (w_state_nxt == ST_DONE) begin
        r_data <= w_imm;
        r_zero <= (w_imm == '0);
      end
    end else if (((r_state == ST_MUL) || (r_state == ST_DIV)) && w_iter_done) begin
      r_data <= w_iter_res;
      r_zero <= (w_iter_res == '0);
    end
  end

endmodule
`default_nettype wire
